id_ex_stage_reg: RTL and testbench

//   ID/EX pipeline register of the 5-stage RISC-V core. Sits directly downstream of the decode

---
 rtl/id_ex_stage_reg.sv | 170 +++++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with load-use hazard detection and bubble counter
module id_ex_stage_reg #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              en,
    input  logic              cnt_clr,
    input  logic [1:0]        id_alu_op,
    input  logic              id_alu_src,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_2_reg,
    input  logic              id_reg_write,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [3:0]        id_func,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic              id_rs2_used,
    input  logic [REG_W-1:0]  id_rd,
    output logic [1:0]        ex_alu_op,
    output logic              ex_alu_src,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_2_reg,
    output logic              ex_reg_write,
    output logic [DATA_W-1:0] ex_rs1_data,
    output logic [DATA_W-1:0] ex_rs2_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [3:0]        ex_func,
    output logic [REG_W-1:0]  ex_rs1,
    output logic [REG_W-1:0]  ex_rs2,
    output logic [REG_W-1:0]  ex_rd,
    output logic              ex_valid,
    output logic              stall_o,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic [1:0]        alu_op_q,    alu_op_d;
    logic              alu_src_q,   alu_src_d;
    logic              mem_read_q,  mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_2_reg_q, mem_2_reg_d;
    logic              reg_write_q, reg_write_d;
    logic [DATA_W-1:0] rs1_data_q,  rs1_data_d;
    logic [DATA_W-1:0] rs2_data_q,  rs2_data_d;
    logic [DATA_W-1:0] imm_q,       imm_d;
    logic [3:0]        func_q,      func_d;
    logic [REG_W-1:0]  rs1_q,       rs1_d;
    logic [REG_W-1:0]  rs2_q,       rs2_d;
    logic [REG_W-1:0]  rd_q,        rd_d;
    logic              valid_q,     valid_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              hazard;

    always_comb begin
        hazard = mem_read_q && (rd_q != '0) &&
                 ((rd_q == id_rs1) || (id_rs2_used && (rd_q == id_rs2)));
        stall_o = hazard & en;

        alu_op_q_hold: begin
            alu_op_d    = alu_op_q;
            alu_src_d   = alu_src_q;
            mem_read_d  = mem_read_q;
            mem_write_d = mem_write_q;
            mem_2_reg_d = mem_2_reg_q;
            reg_write_d = reg_write_q;
            rs1_data_d  = rs1_data_q;
            rs2_data_d  = rs2_data_q;
            imm_d       = imm_q;
            func_d      = func_q;
            rs1_d       = rs1_q;
            rs2_d       = rs2_q;
            rd_d        = rd_q;
            valid_d     = valid_q;
            cnt_d       = cnt_q;
        end

        if (en) begin
            // Operand fields are captured even on a bubble; only control is squashed.
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            func_d     = id_func;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            if (hazard) begin
                alu_op_d    = '0;
                alu_src_d   = 1'b0;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                mem_2_reg_d = 1'b0;
                reg_write_d = 1'b0;
                rd_d        = '0;
                valid_d     = 1'b0;
            end else begin
                alu_op_d    = id_alu_op;
                alu_src_d   = id_alu_src;
                mem_read_d  = id_mem_read;
                mem_write_d = id_mem_write;
                mem_2_reg_d = id_mem_2_reg;
                reg_write_d = id_reg_write;
                rd_d        = id_rd;
                valid_d     = 1'b1;
            end
            if (cnt_clr) begin
                cnt_d = '0;
            end else if (hazard && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            alu_op_q    <= '0;
            alu_src_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_2_reg_q <= 1'b0;
            reg_write_q <= 1'b0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            func_q      <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            valid_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            alu_op_q    <= alu_op_d;
            alu_src_q   <= alu_src_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_2_reg_q <= mem_2_reg_d;
            reg_write_q <= reg_write_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            func_q      <= func_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            valid_q     <= valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ex_alu_op    = alu_op_q;
    assign ex_alu_src   = alu_src_q;
    assign ex_mem_read  = mem_read_q;
    assign ex_mem_write = mem_write_q;
    assign ex_mem_2_reg = mem_2_reg_q;
    assign ex_reg_write = reg_write_q;
    assign ex_rs1_data  = rs1_data_q;
    assign ex_rs2_data  = rs2_data_q;
    assign ex_imm       = imm_q;
    assign ex_func      = func_q;
    assign ex_rs1       = rs1_q;
    assign ex_rs2       = rs2_q;
    assign ex_rd        = rd_q;
    assign ex_valid     = valid_q;
    assign bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb/tb_id_ex_stage_reg.sv - randomized self-checking bench for id_ex_stage_reg
module tb_id_ex_stage_reg;
    localparam int DATA_W  = 64;
    localparam int REG_W   = 5;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              arst, en, cnt_clr;
    logic [1:0]        id_alu_op;
    logic              id_alu_src, id_mem_read, id_mem_write, id_mem_2_reg, id_reg_write;
    logic [DATA_W-1:0] id_rs1_data, id_rs2_data, id_imm;
    logic [3:0]        id_func;
    logic [REG_W-1:0]  id_rs1, id_rs2, id_rd;
    logic              id_rs2_used;
    logic [1:0]        ex_alu_op;
    logic              ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_2_reg, ex_reg_write;
    logic [DATA_W-1:0] ex_rs1_data, ex_rs2_data, ex_imm;
    logic [3:0]        ex_func;
    logic [REG_W-1:0]  ex_rs1, ex_rs2, ex_rd;
    logic              ex_valid, stall_o;
    logic [CNT_W-1:0]  bubble_cnt;

    id_ex_stage_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .arst(arst), .en(en), .cnt_clr(cnt_clr),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_2_reg(id_mem_2_reg), .id_reg_write(id_reg_write),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_func(id_func), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_2_reg(ex_mem_2_reg), .ex_reg_write(ex_reg_write),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_func(ex_func), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_valid(ex_valid), .stall_o(stall_o), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference EX-stage contents: what instruction occupies EX, as plain values.
    logic [1:0]        m_alu_op;
    logic              m_alu_src, m_mem_read, m_mem_write, m_mem_2_reg, m_reg_write;
    logic [DATA_W-1:0] m_rs1_data, m_rs2_data, m_imm;
    logic [3:0]        m_func;
    logic [REG_W-1:0]  m_rs1, m_rs2, m_rd;
    logic              m_valid;
    int                m_cnt;

    task automatic check_eq(string tag, logic [255:0] act, logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        {m_alu_op, m_alu_src, m_mem_read, m_mem_write, m_mem_2_reg, m_reg_write} = '0;
        {m_rs1_data, m_rs2_data, m_imm, m_func, m_rs1, m_rs2, m_rd} = '0;
        m_valid = 1'b0;
        m_cnt   = 0;
    endtask

    function automatic bit model_hazard();
        if (!m_mem_read || m_rd == 0) return 1'b0;
        return (m_rd == id_rs1) || (id_rs2_used && m_rd == id_rs2);
    endfunction

    task automatic model_edge();
        bit hz;
        hz = model_hazard();
        if (!en) return;
        m_rs1_data = id_rs1_data; m_rs2_data = id_rs2_data; m_imm = id_imm;
        m_func = id_func; m_rs1 = id_rs1; m_rs2 = id_rs2;
        if (hz) begin
            {m_alu_op, m_alu_src, m_mem_read, m_mem_write, m_mem_2_reg, m_reg_write} = '0;
            m_rd = '0; m_valid = 1'b0;
        end else begin
            m_alu_op = id_alu_op; m_alu_src = id_alu_src; m_mem_read = id_mem_read;
            m_mem_write = id_mem_write; m_mem_2_reg = id_mem_2_reg; m_reg_write = id_reg_write;
            m_rd = id_rd; m_valid = 1'b1;
        end
        if (cnt_clr) m_cnt = 0;
        else if (hz) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
    endtask

    task automatic check_outputs(string tag);
        check_eq({tag, ".ctrl"},
            {ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_2_reg, ex_reg_write, ex_rd},
            {m_alu_op, m_alu_src, m_mem_read, m_mem_write, m_mem_2_reg, m_reg_write, m_rd});
        check_eq({tag, ".data"},
            {ex_rs1_data, ex_rs2_data, ex_imm, ex_func, ex_rs1, ex_rs2},
            {m_rs1_data, m_rs2_data, m_imm, m_func, m_rs1, m_rs2});
        check_eq({tag, ".valid"}, ex_valid, m_valid);
        check_eq({tag, ".cnt"}, bubble_cnt, m_cnt);
    endtask

    // Called just after a falling edge with inputs already set.
    task automatic step(string tag);
        #1;
        check_eq({tag, ".stall"}, stall_o, model_hazard() & en);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic set_instr(bit mr, int rd, int rs1, int rs2, bit used);
        id_alu_op    = 2'($urandom_range(0, 2));
        id_alu_src   = 1'($urandom);
        id_mem_read  = mr;
        id_mem_write = mr ? 1'b0 : 1'($urandom);
        id_mem_2_reg = mr;
        id_reg_write = 1'b1;
        id_rs1_data  = {$urandom, $urandom};
        id_rs2_data  = {$urandom, $urandom};
        id_imm       = {$urandom, $urandom};
        id_func      = 4'($urandom);
        id_rs1       = REG_W'(rs1);
        id_rs2       = REG_W'(rs2);
        id_rd        = REG_W'(rd);
        id_rs2_used  = used;
    endtask

    initial begin
        arst = 1'b1; en = 1'b1; cnt_clr = 1'b0;
        model_reset();
        set_instr(1'b0, 3, 5, 5, 1'b1);
        @(negedge clk);
        #1;
        check_outputs("reset");
        check_eq("reset.stall", stall_o, 1'b0);
        arst = 1'b0;

        // Load-use on rs2: one bubble, then the add enters EX
        set_instr(1'b1, 5, 2, 0, 1'b0); step("t1.lw");
        set_instr(1'b0, 6, 1, 5, 1'b1); step("t1.bubble");
        check_eq("t1.bubble_valid", ex_valid, 1'b0);
        step("t1.add");
        check_eq("t1.add_rd", ex_rd, 5'd6);
        check_eq("t1.cnt", bubble_cnt, 4'd1);

        // rs2 field matches but unused
        set_instr(1'b1, 5, 2, 0, 1'b0); step("t2.lw");
        set_instr(1'b0, 7, 0, 5, 1'b0); step("t2.addi");
        check_eq("t2.valid", ex_valid, 1'b1);

        // Load to x0 never stalls
        set_instr(1'b1, 0, 2, 0, 1'b0); step("t3.lw");
        set_instr(1'b0, 6, 0, 0, 1'b1); step("t3.add");
        check_eq("t3.cnt", bubble_cnt, 4'd1);

        // Freeze with hazard pending
        set_instr(1'b1, 5, 2, 0, 1'b0); step("t4.lw");
        set_instr(1'b0, 6, 5, 1, 1'b1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) step("t4.frozen");
        check_eq("t4.rd_held", ex_rd, 5'd5);
        en = 1'b1;
        step("t4.release");

        // Saturation then clear-with-hazard
        for (int i = 0; i < 17; i++) begin
            set_instr(1'b1, 5, 2, 0, 1'b0); step("t5.lw");
            set_instr(1'b0, 6, 5, 1, 1'b1); step("t5.bubble");
        end
        check_eq("t5.saturated", bubble_cnt, 4'd15);
        set_instr(1'b1, 5, 2, 0, 1'b0); step("t5.lw_clr");
        set_instr(1'b0, 6, 5, 1, 1'b1); cnt_clr = 1'b1; step("t5.clr");
        check_eq("t5.cleared", bubble_cnt, 4'd0);
        cnt_clr = 1'b0;

        // Asynchronous reset between edges
        set_instr(1'b1, 5, 2, 0, 1'b0); step("t6.lw");
        set_instr(1'b0, 6, 5, 1, 1'b1);
        #1;
        check_eq("t6.stall_before", stall_o, 1'b1);
        arst = 1'b1;
        #1;
        model_reset();
        check_outputs("t6.in_reset");
        check_eq("t6.stall_reset", stall_o, 1'b0);
        arst = 1'b0;
        step("t6.after");
        check_eq("t6.after_rd", ex_rd, 5'd6);
        check_eq("t6.after_valid", ex_valid, 1'b1);

        // Random traffic; a stalled ID instruction is re-presented unchanged
        for (int i = 0; i < 600; i++) begin
            if (!(model_hazard() && en))
                set_instr(1'($urandom_range(0, 1)), $urandom_range(0, 7),
                          $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom));
            en      = ($urandom_range(0, 9) != 0);
            cnt_clr = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 99) == 0) begin
                #2;
                arst = 1'b1;
                #1;
                model_reset();
                check_outputs("rnd.arst");
                arst = 1'b0;
            end
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
